// File: rtl/lc3b_mem_arbiter.sv
// ============================================================================
// Module : lc3b_mem_arbiter
// Desc   : Round-robin I/D line-memory arbiter with a one-line ifetch buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ifetch_read,
  input  logic [11:0]  ifetch_address,
  output logic [127:0] ifetch_rdata,
  output logic         ifetch_resp,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [11:0]  mem_address,
  input  logic [127:0] mem_wdata,
  input  logic [15:0]  mem_sel,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [11:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic [15:0]  pmem_sel,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_HIT   = 3'd1,
    I_MISS  = 3'd2,
    D_READ  = 3'd3,
    D_WRITE = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic c_GRANT_I = 1'b0;
  localparam logic c_GRANT_D = 1'b1;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_last_grant;
  logic [11:0]    r_addr;
  logic [127:0]   r_wdata;
  logic [15:0]    r_sel;
  logic [127:0]   r_rdata;
  logic [11:0]    r_buf_tag;
  logic [127:0]   r_buf_line;
  logic           r_buf_valid;

  logic           w_i_pend;
  logic           w_d_pend;
  logic           w_grant;
  logic           w_grant_d;
  logic           w_i_hit;

  assign w_i_pend  = ifetch_read;
  assign w_d_pend  = mem_read | mem_write;
  assign w_grant   = (r_state == IDLE) && (w_i_pend || w_d_pend);
  // With both ports pending, the port served last time yields.
  assign w_grant_d = w_d_pend && (!w_i_pend || (r_last_grant == c_GRANT_I));
  assign w_i_hit   = r_buf_valid && (r_buf_tag == ifetch_address);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_grant_d) begin
            w_next_state = mem_write ? D_WRITE : D_READ;
          end else begin
            w_next_state = w_i_hit ? I_HIT : I_MISS;
          end
        end
      end
      I_HIT:                   w_next_state = RESP;
      I_MISS, D_READ, D_WRITE: if (pmem_resp) w_next_state = RESP;
      RESP:                    w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_GRANT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
      r_rdata      <= '0;
      r_buf_tag    <= '0;
      r_buf_line   <= '0;
      r_buf_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_last_grant <= w_grant_d;
            if (w_grant_d) begin
              r_addr  <= mem_address;
              r_wdata <= mem_write ? mem_wdata : '0;
              r_sel   <= mem_write ? mem_sel   : '0;
              // A store into the buffered line makes the buffer stale.
              if (mem_write && (mem_address == r_buf_tag)) begin
                r_buf_valid <= 1'b0;
              end
            end else begin
              r_addr  <= ifetch_address;
              r_wdata <= '0;
              r_sel   <= '0;
            end
          end
        end
        I_HIT: r_rdata <= r_buf_line;
        I_MISS: begin
          if (pmem_resp) begin
            r_rdata     <= pmem_rdata;
            r_buf_line  <= pmem_rdata;
            r_buf_tag   <= r_addr;
            r_buf_valid <= 1'b1;
          end
        end
        D_READ: begin
          if (pmem_resp) begin
            r_rdata <= pmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign pmem_read    = (r_state == I_MISS) || (r_state == D_READ);
  assign pmem_write   = (r_state == D_WRITE);
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_sel     = r_sel;

  assign ifetch_resp  = (r_state == RESP) && (r_last_grant == c_GRANT_I);
  assign mem_resp     = (r_state == RESP) && (r_last_grant == c_GRANT_D);
  assign ifetch_rdata = r_rdata;
  assign mem_rdata    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
// ============================================================================
// Module : tb_lc3b_mem_arbiter
// Desc   : Scoreboard bench for lc3b_mem_arbiter with a line-memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3b_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ifetch_read;
  logic [11:0]  ifetch_address;
  logic [127:0] ifetch_rdata;
  logic         ifetch_resp;
  logic         mem_read;
  logic         mem_write;
  logic [11:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_sel;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [11:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_sel;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  lc3b_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
    .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_sel(pmem_sel), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit           port_d;
    bit           is_write;
    bit           pmem_rd;
    bit           pmem_wr;
    logic [11:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  sel;
    logic [127:0] rdata;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         me;
  int           tests = 0;
  int           fails = 0;
  logic [127:0] ref_mem  [0:4095];
  logic [127:0] phys_mem [0:4095];

  // Transaction-level reference state
  bit           m_last_d;
  bit           m_buf_valid;
  logic [11:0]  m_buf_tag;

  bit           pmem_hold = 1'b0;
  int           fixed_lat = -1;
  int           rsp_lat;
  bit           rsp_busy;
  bit           saw_req, prev_active, prev_presp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 12'($urandom);
    return 12'h010 + 12'($urandom_range(0, 3));
  endfunction

  // Physical memory: random latency, occasional stray pmem_resp when idle
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    rsp_busy   = 1'b0;
    rsp_lat    = 0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (!rsp_busy) begin
          rsp_busy = 1'b1;
          rsp_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (!pmem_hold) begin
          if (rsp_lat == 0) begin
            pmem_resp = 1'b1;
            if (pmem_write) begin
              for (int b = 0; b < 16; b++)
                if (pmem_sel[b]) phys_mem[pmem_address][b*8 +: 8] = pmem_wdata[b*8 +: 8];
            end else begin
              pmem_rdata = phys_mem[pmem_address];
            end
          end else begin
            rsp_lat--;
          end
        end
      end else begin
        rsp_busy = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Monitor: checks pmem traffic against the head of the scoreboard, pops on resp
  initial begin
    saw_req = 0; prev_active = 0; prev_presp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        saw_req = 0; prev_active = 0; prev_presp = 0;
      end else begin
        if (pmem_read || pmem_write) begin
          if (exp_q.size() == 0) begin
            check("pmem_unexpected", 128'({pmem_read, pmem_write}), 128'(0));
          end else begin
            me = exp_q[0];
            check("pmem_kind", 128'({pmem_read, pmem_write}), 128'({me.pmem_rd, me.pmem_wr}));
            check("pmem_addr", 128'(pmem_address), 128'(me.addr));
            if (me.pmem_wr) begin
              check("pmem_wdata", pmem_wdata, me.wdata);
              check("pmem_sel", 128'(pmem_sel), 128'(me.sel));
            end
          end
          saw_req = 1;
        end
        if (ifetch_resp || mem_resp) begin
          check("resp_exclusive", 128'(ifetch_resp & mem_resp), 128'(0));
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 128'({ifetch_resp, mem_resp}), 128'(0));
          end else begin
            me = exp_q.pop_front();
            check("resp_port", 128'(mem_resp), 128'(me.port_d));
            if (!me.is_write)
              check("rdata", me.port_d ? mem_rdata : ifetch_rdata, me.rdata);
            check("pmem_used", 128'(saw_req), 128'(me.pmem_rd | me.pmem_wr));
            if (me.pmem_rd | me.pmem_wr)
              check("resp_timing", 128'({prev_active, prev_presp, pmem_read | pmem_write}),
                    128'(3'b110));
          end
          saw_req = 0;
        end
        prev_active = pmem_read | pmem_write;
        prev_presp  = pmem_resp;
      end
    end
  end

  // Predict one grant from the requests currently driven, then wait for its response.
  // Entered and left at negedge+1 of a cycle in which the DUT is idle.
  task automatic run_grant(input bit scramble, output bit gd);
    exp_t e;
    int   cnt;
    bit   ip, dp, hit, got;
    ip = ifetch_read;
    dp = mem_read | mem_write;
    gd = dp && (!ip || !m_last_d);
    m_last_d = gd;
    e = '{default: 0};
    if (gd) begin
      e.port_d = 1;
      e.addr   = mem_address;
      if (mem_write) begin
        e.is_write = 1;
        e.pmem_wr  = 1;
        e.wdata    = mem_wdata;
        e.sel      = mem_sel;
        for (int b = 0; b < 16; b++)
          if (mem_sel[b]) ref_mem[mem_address][b*8 +: 8] = mem_wdata[b*8 +: 8];
        if (mem_address == m_buf_tag) m_buf_valid = 0;
      end else begin
        e.pmem_rd = 1;
        e.rdata   = ref_mem[mem_address];
      end
    end else begin
      e.addr      = ifetch_address;
      e.rdata     = ref_mem[ifetch_address];
      hit         = m_buf_valid && (m_buf_tag == ifetch_address);
      e.pmem_rd   = !hit;
      m_buf_valid = 1;
      m_buf_tag   = ifetch_address;
    end
    exp_q.push_back(e);
    @(posedge clk);
    got = 0;
    cnt = 0;
    while (!got && cnt < 60) begin
      @(negedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        check("req_start", 128'({pmem_read, pmem_write}), 128'({e.pmem_rd, e.pmem_wr}));
        if (scramble) begin
          if ($urandom_range(0, 1) == 1) begin
            if (gd) begin
              mem_address = 12'($urandom);
              mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
              mem_sel     = 16'($urandom);
            end else begin
              ifetch_address = 12'($urandom);
            end
          end
          if ($urandom_range(0, 2) == 0) begin
            if (gd) begin mem_read = 0; mem_write = 0; end
            else ifetch_read = 0;
          end
        end
      end
      got = ifetch_resp | mem_resp;
    end
    if (!got) begin
      check("resp_timeout", 128'(got), 128'(1));
      exp_q.delete();
    end else if (!e.pmem_rd && !e.pmem_wr) begin
      check("hit_latency", 128'(cnt), 128'(2));
    end
    @(negedge clk); #1;
  endtask

  task automatic new_i();
    ifetch_read    = 1;
    ifetch_address = rand_addr();
  endtask

  task automatic new_d();
    int op;
    op          = int'($urandom_range(0, 3));
    mem_read    = (op == 0) || (op == 3);
    mem_write   = (op != 0);
    mem_address = rand_addr();
    mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
    mem_sel     = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   g, last_gd, have_last;
    exp_t e;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
      phys_mem[i] = ref_mem[i];
    end
    rst_n = 0;
    ifetch_read = 0; ifetch_address = '0;
    mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; mem_sel = '0;
    m_last_d = 0; m_buf_valid = 0; m_buf_tag = '0;
    #2;
    check("rst_ctrl", 128'({pmem_read, pmem_write, ifetch_resp, mem_resp}), 128'(0));
    check("rst_pmem_addr", 128'(pmem_address), 128'(0));
    check("rst_pmem_wdata", pmem_wdata, 128'(0));
    check("rst_pmem_sel", 128'(pmem_sel), 128'(0));
    check("rst_ifetch_rdata", ifetch_rdata, 128'(0));
    check("rst_mem_rdata", mem_rdata, 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;

    // Cold fetch, then a buffered repeat of the same line
    fixed_lat = 2;
    ifetch_read = 1; ifetch_address = 12'h010;
    run_grant(0, g);
    run_grant(0, g);
    ifetch_read = 0;
    fixed_lat = -1;

    // Simultaneous requests alternate
    ifetch_read = 1; ifetch_address = 12'h030;
    mem_read = 1; mem_address = 12'h020;
    run_grant(0, g);
    if (g) begin mem_read = 0; end else ifetch_read = 0;
    run_grant(0, g);
    ifetch_read = 1; ifetch_address = 12'h031;
    mem_read = 1; mem_address = 12'h021;
    run_grant(0, g);
    if (g) begin mem_read = 0; end else ifetch_read = 0;
    run_grant(0, g);
    ifetch_read = 0; mem_read = 0;

    // Store into the buffered line forces the next fetch to miss
    ifetch_read = 1; ifetch_address = 12'h010;
    run_grant(0, g);
    ifetch_read = 0;
    mem_write = 1; mem_address = 12'h010; mem_sel = 16'h0003;
    mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    run_grant(0, g);
    mem_write = 0;
    ifetch_read = 1; ifetch_address = 12'h010;
    run_grant(0, g);
    ifetch_read = 0;

    // Read and write together behave as a write
    mem_read = 1; mem_write = 1; mem_address = 12'h022; mem_sel = 16'hF0F0;
    mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    run_grant(0, g);
    mem_read = 1; mem_write = 0;
    run_grant(0, g);
    mem_read = 0;

    // Randomized traffic; the port just served is refreshed, the other stays pending
    have_last = 0;
    last_gd   = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ifetch_read || (have_last && !last_gd)) begin
        if ($urandom_range(0, 2) != 0) new_i(); else ifetch_read = 0;
      end
      if (!(mem_read || mem_write) || (have_last && last_gd)) begin
        if ($urandom_range(0, 2) != 0) new_d(); else begin mem_read = 0; mem_write = 0; end
      end
      if (ifetch_read || mem_read || mem_write) begin
        run_grant(1, last_gd);
        have_last = 1;
      end else begin
        have_last = 0;
        @(negedge clk); #1;
      end
    end
    ifetch_read = 0; mem_read = 0; mem_write = 0;
    @(negedge clk); #1;

    // Reset while a fill is outstanding
    ifetch_read = 1; ifetch_address = 12'h030;
    run_grant(0, g);
    ifetch_read = 0;
    pmem_hold = 1;
    ifetch_read = 1; ifetch_address = 12'h040;
    e = '{default: 0};
    e.addr = 12'h040;
    e.pmem_rd = 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk); #1;
    check("hold_req", 128'(pmem_read), 128'(1));
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    check("reset_drop_req", 128'({pmem_read, pmem_write}), 128'(0));
    check("reset_no_resp", 128'({ifetch_resp, mem_resp}), 128'(0));
    exp_q.delete();
    ifetch_read = 0;
    m_last_d = 0;
    m_buf_valid = 0;
    pmem_hold = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    @(negedge clk); #1;
    ifetch_read = 1; ifetch_address = 12'h030;
    run_grant(0, g);
    ifetch_read = 0;
    repeat (4) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
